// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment capture block:
// segment patterns, tracker states and the decode result type.
package seg_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_W = 4;

    // Active-high patterns, bit0 = a ... bit6 = g
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        TRK_IDLE   = 2'd0,
        TRK_TRACK  = 2'd1,
        TRK_LOCKED = 2'd2
    } trk_state_e;

    typedef struct packed {
        logic [DIG_W-1:0] code;
        logic             is_blank;
        logic             is_invalid;
    } seg_dec_t;

endpackage

// File: rtl/seg_decode7.sv
// Combinational active-high seven-segment pattern to hex decoder.
module seg_decode7
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output seg_dec_t         dec_c
);

    always_comb begin
        dec_c            = '0;
        dec_c.is_blank   = 1'b0;
        dec_c.is_invalid = 1'b0;
        case (seg)
            SEG_0:     dec_c.code = 4'h0;
            SEG_1:     dec_c.code = 4'h1;
            SEG_2:     dec_c.code = 4'h2;
            SEG_3:     dec_c.code = 4'h3;
            SEG_4:     dec_c.code = 4'h4;
            SEG_5:     dec_c.code = 4'h5;
            SEG_6:     dec_c.code = 4'h6;
            SEG_7:     dec_c.code = 4'h7;
            SEG_8:     dec_c.code = 4'h8;
            SEG_9:     dec_c.code = 4'h9;
            SEG_A:     dec_c.code = 4'hA;
            SEG_B:     dec_c.code = 4'hB;
            SEG_C:     dec_c.code = 4'hC;
            SEG_D:     dec_c.code = 4'hD;
            SEG_E:     dec_c.code = 4'hE;
            SEG_F:     dec_c.code = 4'hF;
            SEG_BLANK: dec_c.is_blank = 1'b1;
            default:   dec_c.is_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_capture_multi.sv
// Captures a multiplexed seven-segment bus into per-digit hex values with a
// stability filter. Optional decimal-point capture via `define SEGCAP_DP_EN.
module seg_capture_multi
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned SEL_W          = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [SEG_W-1:0]            seg_in,
    input  logic [SEL_W-1:0]            digit_sel,
    input  logic                        clear_err,
`ifdef SEGCAP_DP_EN
    input  logic                        dp_in,
    output logic [NUM_DIGITS-1:0]       digit_dp,
`endif
    output logic [DIG_W*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]       digit_valid,
    output logic [NUM_DIGITS-1:0]       digit_err,
    output logic                        any_err,
    output logic                        update
);

    localparam logic [1:0]       IDLE     = TRK_IDLE;
    localparam logic [1:0]       TRACK    = TRK_TRACK;
    localparam logic [1:0]       LOCKED   = TRK_LOCKED;
    localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SEG_W-1:0]            samp_seg;
    logic [SEL_W-1:0]            samp_sel;
    logic [1:0]                  state_q;
    logic [1:0]                  state_nxt;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_nxt;
    logic                        same_c;
    logic                        sel_ok_c;
    logic                        restart_c;
    logic                        commit_c;
    logic                        changed_c;
    logic [SEG_W-1:0]            seg_norm_c;
    seg_dec_t                    dec_c;
    logic [DIG_W*NUM_DIGITS-1:0] val_nxt;
    logic [NUM_DIGITS-1:0]       valid_nxt;
    logic [NUM_DIGITS-1:0]       err_nxt;
`ifdef SEGCAP_DP_EN
    logic                        samp_dp;
    logic                        dp_norm_c;
    logic [NUM_DIGITS-1:0]       dp_nxt;
`endif

    // The sample register holds the previous sample; the tracker judges the
    // incoming sample so a commit lands on the same edge that samples it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            samp_seg <= '0;
            samp_sel <= '0;
`ifdef SEGCAP_DP_EN
            samp_dp  <= 1'b0;
`endif
        end else begin
            samp_seg <= seg_in;
            samp_sel <= digit_sel;
`ifdef SEGCAP_DP_EN
            samp_dp  <= dp_in;
`endif
        end
    end

    assign seg_norm_c = (SEG_ACTIVE_LOW != 0) ? ~seg_in : seg_in;
    assign sel_ok_c   = ({1'b0, digit_sel} < (SEL_W+1)'(NUM_DIGITS));
`ifdef SEGCAP_DP_EN
    assign dp_norm_c  = (SEG_ACTIVE_LOW != 0) ? ~dp_in : dp_in;
    assign same_c     = (seg_in == samp_seg) && (digit_sel == samp_sel) && (dp_in == samp_dp);
`else
    assign same_c     = (seg_in == samp_seg) && (digit_sel == samp_sel);
`endif

    seg_decode7 u_decode (
        .seg   (seg_norm_c),
        .dec_c (dec_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Tracker: a fresh pattern restarts the count at 1; reaching STABLE_N commits
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        restart_c = 1'b0;
        commit_c  = 1'b0;
        if (!sel_ok_c) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state_q)
                IDLE: restart_c = 1'b1;
                TRACK: begin
                    if (same_c) begin
                        cnt_nxt = cnt_q + CNT_ONE;
                        if (cnt_nxt == STABLE_N) begin
                            commit_c  = 1'b1;
                            state_nxt = LOCKED;
                        end
                    end else begin
                        restart_c = 1'b1;
                    end
                end
                LOCKED: restart_c = !same_c;
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
        if (restart_c) begin
            state_nxt = TRACK;
            cnt_nxt   = CNT_ONE;
            if (STABLE_N == CNT_ONE) begin
                commit_c  = 1'b1;
                state_nxt = LOCKED;
            end
        end
    end

    // Commit: apply the decoded sample to the selected digit
    always_comb begin
        val_nxt   = digit_val;
        valid_nxt = digit_valid;
        err_nxt   = clear_err ? '0 : digit_err;
`ifdef SEGCAP_DP_EN
        dp_nxt    = digit_dp;
`endif
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (commit_c && (digit_sel == SEL_W'(i))) begin
                if (dec_c.is_invalid) begin
                    err_nxt[i] = 1'b1;
                end else if (dec_c.is_blank) begin
                    valid_nxt[i] = 1'b0;
`ifdef SEGCAP_DP_EN
                    dp_nxt[i]    = dp_norm_c;
`endif
                end else begin
                    val_nxt[DIG_W*i +: DIG_W] = dec_c.code;
                    valid_nxt[i]              = 1'b1;
`ifdef SEGCAP_DP_EN
                    dp_nxt[i]                 = dp_norm_c;
`endif
                end
            end
        end
`ifdef SEGCAP_DP_EN
        changed_c = (val_nxt != digit_val) || (valid_nxt != digit_valid) || (dp_nxt != digit_dp);
`else
        changed_c = (val_nxt != digit_val) || (valid_nxt != digit_valid);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit_val   <= '0;
            digit_valid <= '0;
            digit_err   <= '0;
            any_err     <= 1'b0;
            update      <= 1'b0;
`ifdef SEGCAP_DP_EN
            digit_dp    <= '0;
`endif
        end else begin
            digit_val   <= val_nxt;
            digit_valid <= valid_nxt;
            digit_err   <= err_nxt;
            any_err     <= |err_nxt;
            update      <= changed_c;
`ifdef SEGCAP_DP_EN
            digit_dp    <= dp_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_seg_capture_multi.sv
// Directed bench for seg_capture_multi: active-low, active-high and
// three-digit instances driven from one linear stimulus sequence.
module tb_seg_capture_multi;

    logic        clock = 1'b0;
    logic        reset_n;

    logic [6:0]  seg_a, seg_h, seg_3;
    logic        sel_a, sel_h;
    logic [1:0]  sel_3;
    logic        clr_a, clr_h, clr_3;

    logic [7:0]  val_a, val_h;
    logic [11:0] val_3;
    logic [1:0]  valid_a, valid_h, err_a, err_h;
    logic [2:0]  valid_3, err_3;
    logic        any_a, any_h, any_3;
    logic        update_a, update_h, update_3;

`ifdef SEGCAP_DP_EN
    logic        dp_a = 1'b1;
    logic        dp_h = 1'b0;
    logic        dp_3 = 1'b1;
    logic [1:0]  ddp_a, ddp_h;
    logic [2:0]  ddp_3;
`endif

    int total = 0;
    int bad   = 0;
    int upd_a = 0;
    int upd_h = 0;
    int upd_3 = 0;

    always #5 clock = ~clock;

    seg_capture_multi #(
        .NUM_DIGITS(2), .SEL_W(1), .SEG_ACTIVE_LOW(1), .STABLE_CYCLES(4), .CNT_W(8)
    ) u_a (
        .clock(clock), .reset_n(reset_n), .seg_in(seg_a), .digit_sel(sel_a), .clear_err(clr_a),
`ifdef SEGCAP_DP_EN
        .dp_in(dp_a), .digit_dp(ddp_a),
`endif
        .digit_val(val_a), .digit_valid(valid_a), .digit_err(err_a), .any_err(any_a), .update(update_a)
    );

    seg_capture_multi #(
        .NUM_DIGITS(2), .SEL_W(1), .SEG_ACTIVE_LOW(0), .STABLE_CYCLES(4), .CNT_W(8)
    ) u_h (
        .clock(clock), .reset_n(reset_n), .seg_in(seg_h), .digit_sel(sel_h), .clear_err(clr_h),
`ifdef SEGCAP_DP_EN
        .dp_in(dp_h), .digit_dp(ddp_h),
`endif
        .digit_val(val_h), .digit_valid(valid_h), .digit_err(err_h), .any_err(any_h), .update(update_h)
    );

    seg_capture_multi #(
        .NUM_DIGITS(3), .SEL_W(2), .SEG_ACTIVE_LOW(1), .STABLE_CYCLES(4), .CNT_W(8)
    ) u_3 (
        .clock(clock), .reset_n(reset_n), .seg_in(seg_3), .digit_sel(sel_3), .clear_err(clr_3),
`ifdef SEGCAP_DP_EN
        .dp_in(dp_3), .digit_dp(ddp_3),
`endif
        .digit_val(val_3), .digit_valid(valid_3), .digit_err(err_3), .any_err(any_3), .update(update_3)
    );

    // Advance n rising edges, sampling 1 time unit after each and tallying update pulses
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            upd_a += int'(update_a);
            upd_h += int'(update_h);
            upd_3 += int'(update_3);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        seg_a = 7'h7F; sel_a = 1'b0; clr_a = 1'b0;
        seg_h = 7'h00; sel_h = 1'b0; clr_h = 1'b0;
        seg_3 = 7'h7F; sel_3 = 2'd0; clr_3 = 1'b0;
        tick(3);
        check("rst_val",    32'(val_a),    32'h0);
        check("rst_valid",  32'(valid_a),  32'h0);
        check("rst_err",    32'(err_a),    32'h0);
        check("rst_any",    32'(any_a),    32'h0);
        check("rst_update", 32'(update_a), 32'h0);
        check("rst_val3",   32'(val_3),    32'h0);
        reset_n = 1'b1;
        tick(2);

        // Select flips every 2 cycles: never stable long enough to commit
        upd_a = 0;
        for (int i = 0; i < 8; i++) begin
            sel_a = i[0];
            seg_a = i[0] ? ~7'h7F : ~7'h06;
            tick(2);
        end
        check("flicker_val",   32'(val_a),   32'h0);
        check("flicker_valid", 32'(valid_a), 32'h0);
        check("flicker_upd",   32'(upd_a),   32'h0);

        // Alternate digits every 8 cycles: "1" on digit 0, "8" on digit 1
        upd_a = 0;
        sel_a = 1'b0; seg_a = ~7'h06;
        tick(3);
        check("lat_pre_valid", 32'(valid_a), 32'h0);
        tick(1);
        check("lat_val",       32'(val_a),    32'h01);
        check("lat_valid",     32'(valid_a),  32'h1);
        check("lat_update",    32'(update_a), 32'h1);
        tick(1);
        check("lat_update_off", 32'(update_a), 32'h0);
        tick(3);
        sel_a = 1'b1; seg_a = ~7'h7F;
        tick(8);
        check("alt_val_mid", 32'(val_a), 32'h81);
        sel_a = 1'b0; seg_a = ~7'h06;
        tick(8);
        sel_a = 1'b1; seg_a = ~7'h7F;
        tick(8);
        check("alt_val",   32'(val_a),   32'h81);
        check("alt_valid", 32'(valid_a), 32'h3);
        check("alt_upd",   32'(upd_a),   32'h2);

        // Non-hex pattern on digit 1 is an error-only commit
        upd_a = 0;
        sel_a = 1'b1; seg_a = ~7'h49;
        tick(6);
        check("inv_err",   32'(err_a),   32'h2);
        check("inv_any",   32'(any_a),   32'h1);
        check("inv_val",   32'(val_a),   32'h81);
        check("inv_valid", 32'(valid_a), 32'h3);
        check("inv_upd",   32'(upd_a),   32'h0);

        // clear_err on the same edge as an invalid commit to digit 0
        sel_a = 1'b0; seg_a = ~7'h49;
        tick(3);
        check("clrset_pre", 32'(err_a), 32'h2);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        check("clrset_err", 32'(err_a), 32'h1);
        check("clrset_any", 32'(any_a), 32'h1);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        check("clr_err", 32'(err_a), 32'h0);
        check("clr_any", 32'(any_a), 32'h0);

        // Active-high instance: "0" then blank drops valid but keeps the value
        upd_h = 0;
        seg_h = 7'h3F;
        tick(4);
        check("ah_update", 32'(update_h), 32'h1);
        check("ah_valid",  32'(valid_h),  32'h1);
        check("ah_val",    32'(val_h),    32'h0);
        tick(2);
        upd_h = 0;
        seg_h = 7'h00;
        tick(5);
        check("blank_valid", 32'(valid_h), 32'h0);
        check("blank_val",   32'(val_h),   32'h0);
        check("blank_upd",   32'(upd_h),   32'h1);

        // Three digits: out-of-range select never commits
        upd_3 = 0;
        sel_3 = 2'd3; seg_3 = ~7'h06;
        tick(8);
        check("oor_valid", 32'(valid_3), 32'h0);
        check("oor_val",   32'(val_3),   32'h0);
        check("oor_upd",   32'(upd_3),   32'h0);
        sel_3 = 2'd2; seg_3 = ~7'h5B;
        tick(4);
        check("d2_val",    32'(val_3),    32'h200);
        check("d2_valid",  32'(valid_3),  32'h4);
        check("d2_update", 32'(update_3), 32'h1);

        // Reset mid-track clears everything without waiting for an edge
        sel_3 = 2'd1; seg_3 = ~7'h7F;
        tick(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_val3",   32'(val_3),   32'h0);
        check("arst_valid3", 32'(valid_3), 32'h0);
        check("arst_val_a",  32'(val_a),   32'h0);
        check("arst_valid_a", 32'(valid_a), 32'h0);
        tick(1);
        reset_n = 1'b1;
        tick(3);
        check("post_rst_pre", 32'(valid_3), 32'h0);
        tick(1);
        check("post_rst_valid", 32'(valid_3), 32'h2);
        check("post_rst_val",   32'(val_3),   32'h080);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_capture_multi.md
Name: seg_capture_multi

Overview:
- Parametrised successor to the two-digit simulation segment converter.
- Watches a multiplexed seven-segment bus (N digits, binary digit select) driven by the chip under test.
- Decodes each digit back to hex, applies a stability filter so the multiplex flicker does not glitch the outputs, and holds per-digit value, valid and sticky error flags.
- Sits beside the chip model in the top-level simulation harness; written synthesizable.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits (1..16).
- SEL_W, 1, digit_sel width; must satisfy 2**SEL_W >= NUM_DIGITS.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0; 0 = lit when bit is 1.
- STABLE_CYCLES, 4, consecutive identical samples required to commit (1..255).
- CNT_W, 8, stability counter width; must hold STABLE_CYCLES.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  segment bus; bit0 = a … bit6 = g.
- digit_sel  in  SEL_W  index of the digit currently driven on seg_in.
- clear_err  in  1  synchronous clear of all digit_err bits.
- digit_val  out  4*NUM_DIGITS  held hex value; digit i occupies bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digit i holds a committed hex value.
- digit_err  out  NUM_DIGITS  sticky: digit i committed an undecodable pattern.
- any_err  out  1  OR of digit_err.
- update  out  1  one-cycle pulse when any digit_val/digit_valid changes.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; tracker in IDLE; sample registers 0.
- Sample stage:
  - seg_in and digit_sel are registered every cycle.
  - Polarity is normalised to active-high after the register when SEG_ACTIVE_LOW = 1.
- Decode (combinational on the sample):
  - Standard 0-9, A, b, C, d, E, F patterns map to 4-bit codes.
  - All segments off = BLANK.
  - Any other pattern = INVALID.
- Tracker FSM, states IDLE, TRACK, LOCKED, with counter cnt:
  - The current sample is "same" when its sel and pattern equal the previous sample.
  - Any state, sel >= NUM_DIGITS: go to IDLE, cnt = 0, no commit.
  - IDLE, valid sel: go to TRACK, cnt = 1. If STABLE_CYCLES = 1, commit immediately and go to LOCKED.
  - TRACK, same: cnt++. When cnt reaches STABLE_CYCLES, commit and go to LOCKED.
  - TRACK, not same: cnt = 1, stay in TRACK.
  - LOCKED, same: hold, no re-commit.
  - LOCKED, not same: go to TRACK, cnt = 1.
- Commit to digit s:
  - Hex pattern: digit_val[s] = code, digit_valid[s] = 1.
  - BLANK: digit_valid[s] = 0; digit_val[s] unchanged.
  - INVALID: digit_err[s] = 1; digit_val[s] and digit_valid[s] unchanged.
- update:
  - Asserted the cycle after a commit that changed digit_val[s] or digit_valid[s].
  - Not asserted for an identical re-commit or an error-only commit.
- Latency:
  - Inputs first stable before edge k are sampled at edge k.
  - Outputs reflect the commit after edge k + STABLE_CYCLES − 1.
  - update is high during the following cycle.
- clear_err:
  - Clears every digit_err bit at the next edge.
  - If an INVALID commit happens on the same edge, that digit's bit is set (set wins).
- Simultaneous sel change and pattern change count as a single "not same" event.
- Reset mid-TRACK discards the partial count; held values are lost (reset to 0).
- any_err is registered: it equals the OR of digit_err as updated on the same edge.

Optional Feature:
- Macro: SEGCAP_DP_EN.
- Defined:
  - Adds input dp_in (1) and output digit_dp (NUM_DIGITS).
  - dp_in is sampled, polarity-normalised and compared with the segments for the "same" test.
  - It is committed into digit_dp[s] on hex and BLANK commits, and takes part in the update change test.
- Undefined: no dp port, no digit_dp; behaviour exactly as above.

Decomposition:
- Package seg_pkg:
  - Segment pattern constants SEG_0..SEG_F and SEG_BLANK.
  - Tracker state enum (IDLE, TRACK, LOCKED).
  - Decode result type: code[3:0], is_blank, is_invalid.
- Sub-module seg_decode7: purely combinational pattern-to-code decoder, reused by checkers.

Test Plan:
- Active-low, STABLE_CYCLES=4; sel=0 with ~7'h06 and sel=1 with ~7'h7F, alternating every 8 cycles -> digit_val=8'h81, digit_valid=2'b11, two update pulses, then quiet.
- Alternating sel every 2 cycles (shorter than STABLE_CYCLES) -> no commit, outputs stay 0, update never pulses.
- sel=1 with pattern 7'h49 (non-hex), held 6 cycles -> digit_err=2'b10, any_err=1, digit_val[7:4] unchanged; clear_err pulse -> digit_err=0 next edge.
- clear_err asserted on the same edge as an INVALID commit to digit 0 -> digit_err[0]=1.
- digit 0 shows 7'h3F (active-high instance) then all-off for 5 cycles -> digit_valid[0] drops to 0 with an update pulse; digit_val[3:0] stays 4'h0.
- NUM_DIGITS=3, SEL_W=2, sel=3 held -> tracker in IDLE, no commit; reset_n pulse mid-TRACK -> all outputs 0 asynchronously.
